uart_tx_frame: RTL and testbench

//  Upstream feeder for the byte-wide UART transmitter. Accepts a found-nonce word

---
 rtl/uart_tx_frame.sv | 155 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Frames found nonces as HEADER + nonce bytes (MSB first) + XOR checksum and feeds them
// one byte at a time to a UART transmitter, pacing on its done pulse with a watchdog.
module uart_tx_frame #(
    parameter int unsigned NONCE_WID   = 32,
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NONCE_WID-1:0] iv_nonce,
    input  logic                 i_nonce_vld,
    output logic                 o_ready,
    output logic [7:0]           ov_tx_data,
    output logic                 o_tx_data_vld,
    input  logic                 i_tx_done,
    output logic                 o_frame_done,
    output logic                 o_overflow,
    output logic                 o_timeout
);
    localparam int unsigned BYTE_NUM = NONCE_WID / 8;
    localparam int unsigned IDX_W    = $clog2(BYTE_NUM + 3);
    localparam int unsigned WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_NUM + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]           state;
    logic [NONCE_WID-1:0] active_nonce;
    logic                 active_vld;
    logic [NONCE_WID-1:0] pending_nonce;
    logic                 pending_vld;
    logic [IDX_W-1:0]     byte_idx;
    logic [7:0]           checksum;
    logic [WD_W-1:0]      wdog;
    logic [7:0]           nonce_byte;
    logic [7:0]           cur_byte;
    logic                 accept;
    logic                 to_active;

    // FIN frees the pending slot in the same cycle it is promoted, so a strobe there is legal.
    assign o_ready   = ~pending_vld | (state == S_FIN);
    assign accept    = i_nonce_vld & o_ready;
    assign to_active = accept && (state == S_IDLE) && !active_vld && !pending_vld;

    always_comb begin
        nonce_byte = '0;
        for (int unsigned i = 0; i < BYTE_NUM; i++) begin
            if (byte_idx == IDX_W'(i + 1)) begin
                nonce_byte = active_nonce[NONCE_WID-8-8*i +: 8];
            end
        end
    end

    always_comb begin
        cur_byte = nonce_byte;
        if (byte_idx == '0) begin
            cur_byte = HEADER;
        end else if (byte_idx == LAST_IDX) begin
            cur_byte = checksum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            active_nonce  <= '0;
            active_vld    <= 1'b0;
            pending_nonce <= '0;
            pending_vld   <= 1'b0;
            byte_idx      <= '0;
            checksum      <= '0;
            wdog          <= '0;
            ov_tx_data    <= '0;
            o_tx_data_vld <= 1'b0;
            o_frame_done  <= 1'b0;
            o_overflow    <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_tx_data_vld <= 1'b0;
            o_frame_done  <= 1'b0;
            if (i_nonce_vld && !o_ready) begin
                o_overflow <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (active_vld) begin
                        state <= S_LOAD;
                    end else if (pending_vld) begin
                        active_nonce <= pending_nonce;
                        active_vld   <= 1'b1;
                        pending_vld  <= 1'b0;
                        state        <= S_LOAD;
                    end else if (to_active) begin
                        active_nonce <= iv_nonce;
                        active_vld   <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    byte_idx <= '0;
                    checksum <= '0;
                    wdog     <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    ov_tx_data    <= cur_byte;
                    o_tx_data_vld <= 1'b1;
                    checksum      <= checksum ^ nonce_byte;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        byte_idx <= byte_idx + 1'b1;
                        wdog     <= '0;
                        if (byte_idx == LAST_IDX) begin
                            o_frame_done <= 1'b1;
                            state        <= S_FIN;
                        end else begin
                            state <= S_SEND;
                        end
                    end else if (wdog == WD_LAST) begin
                        o_timeout <= 1'b1;
                        wdog      <= '0;
                        state     <= S_FIN;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_FIN: begin
                    if (pending_vld) begin
                        active_nonce <= pending_nonce;
                        pending_vld  <= 1'b0;
                        state        <= S_LOAD;
                    end else begin
                        active_vld <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept && !to_active) begin
                pending_nonce <= iv_nonce;
                pending_vld   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: expected frame bytes are queued on each accepted
// strobe and compared as the DUT emits them; a simple transmitter model returns done pulses.
module tb_uart_tx_frame;
    localparam int unsigned NW   = 32;
    localparam int unsigned TO   = 50;
    localparam int          DLAT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NW-1:0] iv_nonce = '0;
    logic          i_nonce_vld = 1'b0;
    logic          i_tx_done = 1'b0;
    logic          o_ready;
    logic [7:0]    ov_tx_data;
    logic          o_tx_data_vld;
    logic          o_frame_done;
    logic          o_overflow;
    logic          o_timeout;

    uart_tx_frame #(.NONCE_WID(NW), .HEADER(8'hAA), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .iv_nonce     (iv_nonce),
        .i_nonce_vld  (i_nonce_vld),
        .o_ready      (o_ready),
        .ov_tx_data   (ov_tx_data),
        .o_tx_data_vld(o_tx_data_vld),
        .i_tx_done    (i_tx_done),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    bit         have_done = 1'b0;
    bit         done_en = 1'b1;
    bit         strobe_req = 1'b0;
    logic [NW-1:0] strobe_val = '0;
    int         n_vld = 0;
    int         n_frames = 0;
    int         last_vld_cyc = -1;
    int         first_vld_cyc = -1;

    function automatic void push_frame(input logic [NW-1:0] n);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < NW / 8; i++) begin
            b = n[NW-1-8*i -: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endfunction

    // One clock: drive inputs just after the rising edge, observe on the falling edge.
    task automatic step();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        i_nonce_vld = strobe_req;
        iv_nonce    = strobe_val;
        strobe_req  = 1'b0;
        i_tx_done   = done_en && (done_cnt == 1);
        if (i_tx_done) begin
            done_cyc  = cyc;
            have_done = 1'b1;
        end
        if (done_cnt > 0) done_cnt--;
        @(negedge clk);
        if (o_tx_data_vld) begin
            n_vld++;
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            last_vld_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL tx_byte got=%02h expected=none", ov_tx_data);
            end else begin
                e = exp_q.pop_front();
                if (ov_tx_data !== e) $display("FAIL tx_byte got=%02h expected=%02h", ov_tx_data, e);
                else n_pass++;
            end
            if (have_done) begin
                n_checks++;
                if (cyc != done_cyc + 2) $display("FAIL done_to_vld got=%0d expected=%0d", cyc - done_cyc, 2);
                else n_pass++;
                have_done = 1'b0;
            end
            done_cnt = DLAT;
        end
        if (o_frame_done) begin
            n_frames++;
            have_done = 1'b0;
            n_checks++;
            if (o_ready !== 1'b1) $display("FAIL ready_at_fin got=%b expected=1", o_ready);
            else n_pass++;
        end
    endtask

    task automatic send(input logic [NW-1:0] n, input bit accept);
        strobe_req = 1'b1;
        strobe_val = n;
        if (accept) push_frame(n);
        step();
        n_checks++;
        if (o_ready !== accept) $display("FAIL ready_at_strobe got=%b expected=%b", o_ready, accept);
        else n_pass++;
    endtask

    task automatic clear_bench();
        exp_q.delete();
        strobe_req = 1'b0;
        i_nonce_vld = 1'b0;
        i_tx_done = 1'b0;
        done_cnt = 0;
        have_done = 1'b0;
        done_en = 1'b1;
        n_vld = 0;
        n_frames = 0;
        last_vld_cyc = -1;
        first_vld_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_bench();
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    task automatic run_until_frames(input int target, input int budget);
        int b;
        b = budget;
        while (n_frames < target && b > 0) begin
            step();
            b--;
        end
        repeat (30) step();
        n_checks++;
        if (n_frames != target) $display("FAIL frame_count got=%0d expected=%0d", n_frames, target);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bytes_outstanding got=%0d expected=0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_bench();
        repeat (2) step();
        n_checks++;
        if ({ov_tx_data, o_tx_data_vld, o_frame_done, o_overflow, o_timeout, o_ready} !== 13'b0000_0000_00001)
            $display("FAIL reset_outputs got=%013b expected=%013b",
                     {ov_tx_data, o_tx_data_vld, o_frame_done, o_overflow, o_timeout, o_ready}, 13'b1);
        else n_pass++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        int t;
        int b;
        do_reset();
        send(32'h1234_5678, 1'b1);
        t = cyc;
        b = 10;
        while (first_vld_cyc < 0 && b > 0) begin
            step();
            b--;
        end
        n_checks++;
        if (first_vld_cyc != t + 3) $display("FAIL first_latency got=%0d expected=%0d", first_vld_cyc - t, 3);
        else n_pass++;
        run_until_frames(1, 300);
        n_checks++;
        if (o_overflow !== 1'b0) $display("FAIL single_overflow got=%b expected=0", o_overflow);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(32'hDEAD_BEEF, 1'b1);
        repeat (4) step();
        send(32'h0102_0304, 1'b1);
        step();
        n_checks++;
        if (o_ready !== 1'b0) $display("FAIL ready_after_2nd got=%b expected=0", o_ready);
        else n_pass++;
        repeat (60) step();
        n_checks++;
        if (o_ready !== 1'b0) $display("FAIL ready_mid_frame got=%b expected=0", o_ready);
        else n_pass++;
        run_until_frames(2, 500);
        n_checks++;
        if (o_ready !== 1'b1) $display("FAIL ready_after_frames got=%b expected=1", o_ready);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        send(32'hCAFE_F00D, 1'b1);
        step();
        send(32'h5555_AAAA, 1'b1);
        step();
        send(32'h7777_7777, 1'b0);
        step();
        n_checks++;
        if (o_overflow !== 1'b1) $display("FAIL overflow_flag got=%b expected=1", o_overflow);
        else n_pass++;
        run_until_frames(2, 500);
        n_checks++;
        if (o_overflow !== 1'b1) $display("FAIL overflow_sticky got=%b expected=1", o_overflow);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int b;
        do_reset();
        done_en = 1'b0;
        send(32'h1122_3344, 1'b1);
        b = 200;
        while (o_timeout !== 1'b1 && b > 0) begin
            step();
            b--;
        end
        n_checks++;
        if (o_timeout !== 1'b1 || cyc != last_vld_cyc + TO)
            $display("FAIL timeout_delay got=%0d expected=%0d", cyc - last_vld_cyc, TO);
        else n_pass++;
        repeat (60) step();
        n_checks++;
        if (n_vld != 1 || exp_q.size() != 5) $display("FAIL timeout_bytes got=%0d expected=1", n_vld);
        else n_pass++;
        n_checks++;
        if (n_frames != 0) $display("FAIL timeout_frame_done got=%0d expected=0", n_frames);
        else n_pass++;
        n_checks++;
        if (o_ready !== 1'b1 || o_timeout !== 1'b1)
            $display("FAIL timeout_idle got=%b%b expected=11", o_ready, o_timeout);
        else n_pass++;
        exp_q.delete();
        done_en = 1'b1;
    endtask

    task automatic test_fin_accept();
        int t;
        do_reset();
        send(32'hA1B2_C3D4, 1'b1);
        t = cyc;
        repeat (4) step();
        send(32'h0F1E_2D3C, 1'b1);
        // First frame: byte k valid at t+3+22k, checksum done at t+133, FIN at t+134.
        while (cyc < t + 133) step();
        send(32'h9988_7766, 1'b1);
        n_checks++;
        if (n_frames != 1) $display("FAIL strobe_on_fin got=%0d expected=1", n_frames);
        else n_pass++;
        run_until_frames(3, 700);
        n_checks++;
        if (o_overflow !== 1'b0) $display("FAIL fin_overflow got=%b expected=0", o_overflow);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        int b;
        do_reset();
        send(32'h1357_9BDF, 1'b1);
        step();
        send(32'h2468_ACE0, 1'b1);
        step();
        send(32'h0000_0001, 1'b0);
        b = 200;
        while (n_vld < 3 && b > 0) begin
            step();
            b--;
        end
        repeat (5) step();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ov_tx_data, o_tx_data_vld, o_frame_done, o_overflow, o_timeout, o_ready} !== 13'b0000_0000_00001)
            $display("FAIL async_reset got=%013b expected=%013b",
                     {ov_tx_data, o_tx_data_vld, o_frame_done, o_overflow, o_timeout, o_ready}, 13'b1);
        else n_pass++;
        clear_bench();
        repeat (2) step();
        rst = 1'b1;
        step();
        send(32'hFEDC_BA98, 1'b1);
        run_until_frames(1, 300);
        n_checks++;
        if (n_vld != 6) $display("FAIL fresh_frame_len got=%0d expected=6", n_vld);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_fin_accept();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
